// File: rtl/ex_mem_pipe_if.sv
// EX->MEM write-back bundle: valid/ready handshake plus GPR and CSR write fields.
interface ex_mem_pipe_if #(
    parameter int REG_ADDR_W = 5,
    parameter int REG_DATA_W = 32,
    parameter int CSR_ADDR_W = 12,
    parameter int CSR_DATA_W = 32
) ();
    logic                  valid;
    logic                  ready;
    logic [REG_ADDR_W-1:0] waddr;
    logic [REG_DATA_W-1:0] wdata;
    logic                  we;
    logic                  csr_we;
    logic [CSR_ADDR_W-1:0] csr_waddr;
    logic [CSR_DATA_W-1:0] csr_wdata;

    // Producer side: presents the bundle and observes ready
    modport master (
        output valid, waddr, wdata, we, csr_we, csr_waddr, csr_wdata,
        input  ready
    );

    // Consumer side: receives the bundle and drives ready
    modport slave (
        input  valid, waddr, wdata, we, csr_we, csr_waddr, csr_wdata,
        output ready
    );
endinterface

// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline register with valid/ready handshake, synchronous flush,
// x0 write squash and an optional two-entry skid buffer that registers in_ready.
module ex_mem_pipe #(
    parameter int REG_ADDR_W  = 5,
    parameter int REG_DATA_W  = 32,
    parameter int CSR_ADDR_W  = 12,
    parameter int CSR_DATA_W  = 32,
    parameter int SKID        = 1,
    parameter int ZERO_SQUASH = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    ex_mem_pipe_if.slave  in_bus,
    ex_mem_pipe_if.master out_bus,
    output logic [1:0]   occ
);

    typedef struct packed {
        logic [REG_ADDR_W-1:0] waddr;
        logic [REG_DATA_W-1:0] wdata;
        logic                  we;
        logic                  csr_we;
        logic [CSR_ADDR_W-1:0] csr_waddr;
        logic [CSR_DATA_W-1:0] csr_wdata;
    } bundle_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t  state_q, state_d;
    bundle_t main_q, skid_q, in_b;
    logic    out_valid, in_ready, acc, rel;
    logic    load_main_in, load_main_skid, load_skid;

    assign out_valid = (state_q != EMPTY);
    assign acc       = in_bus.valid & in_ready;
    assign rel       = out_valid & out_bus.ready;

    // Capture the incoming bundle, dropping the write enable for GPR x0 when squashing
    always_comb begin
        in_b           = '0;
        in_b.waddr     = in_bus.waddr;
        in_b.wdata     = in_bus.wdata;
        in_b.we        = in_bus.we & ~((ZERO_SQUASH != 0) && (in_bus.waddr == '0));
        in_b.csr_we    = in_bus.csr_we;
        in_b.csr_waddr = in_bus.csr_waddr;
        in_b.csr_wdata = in_bus.csr_wdata;
    end

    generate
        if (SKID != 0) begin : g_skid
            logic ready_q;

            // Ready is a flop so MEM's ready never reaches EX combinationally
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) ready_q <= 1'b1;
                else      ready_q <= (state_d != TWO);
            end

            assign in_ready = ready_q;
        end else begin : g_noskid
            assign in_ready = ~out_valid | out_bus.ready;
        end
    endgenerate

    // Occupancy state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= EMPTY;
        else      state_q <= state_d;
    end

    // Next occupancy and entry load selects; flush overrides any handshake
    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (acc) begin
                        state_d      = ONE;
                        load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (acc && rel) begin
                        load_main_in = 1'b1;
                    end else if (acc) begin
                        state_d   = TWO;
                        load_skid = 1'b1;
                    end else if (rel) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (rel) begin
                        state_d        = ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Main entry feeds MEM; refilled from EX directly or from the skid entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                main_q <= '0;
        else if (load_main_in)   main_q <= in_b;
        else if (load_main_skid) main_q <= skid_q;
    end

    // Skid entry catches the bundle accepted while MEM is stalled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          skid_q <= '0;
        else if (load_skid) skid_q <= in_b;
    end

    // Occupancy count decoded from the state
    always_comb begin
        occ = 2'd0;
        case (state_q)
            ONE:     occ = 2'd1;
            TWO:     occ = 2'd2;
            default: occ = 2'd0;
        endcase
    end

    assign in_bus.ready      = in_ready;
    assign out_bus.valid     = out_valid;
    assign out_bus.waddr     = main_q.waddr;
    assign out_bus.wdata     = main_q.wdata;
    assign out_bus.we        = main_q.we & out_valid;
    assign out_bus.csr_we    = main_q.csr_we & out_valid;
    assign out_bus.csr_waddr = main_q.csr_waddr;
    assign out_bus.csr_wdata = main_q.csr_wdata;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Bench for ex_mem_pipe: three instances (SKID=1/ZS=1, SKID=0/ZS=1, SKID=1/ZS=0)
// checked every cycle against a queue model plus directed literal checks.
module tb_ex_mem_pipe;

    typedef struct packed {
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        we;
        logic        csr_we;
        logic [11:0] csr_waddr;
        logic [31:0] csr_wdata;
    } bundle_t;

    logic       clk;
    logic       rst;
    logic [2:0] flush;
    logic [2:0] in_valid;
    logic [2:0] out_ready;
    logic [2:0] in_ready;
    logic [2:0] out_valid;
    bundle_t    in_b  [3];
    bundle_t    out_b [3];
    logic [1:0] occ_s [3];
    logic [2:0] rnd_mode;

    bundle_t q [3][$];
    int      csr_cnt [3];
    int      n_checks;
    int      n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int S = (g == 1) ? 0 : 1;
        localparam int Z = (g == 2) ? 0 : 1;
        ex_mem_pipe_if in_if ();
        ex_mem_pipe_if out_if ();

        ex_mem_pipe #(.SKID(S), .ZERO_SQUASH(Z)) dut (
            .clk     (clk),
            .rst     (rst),
            .flush   (flush[g]),
            .in_bus  (in_if),
            .out_bus (out_if),
            .occ     (occ_s[g])
        );

        assign in_if.valid = in_valid[g];
        assign {in_if.waddr, in_if.wdata, in_if.we, in_if.csr_we,
                in_if.csr_waddr, in_if.csr_wdata} = in_b[g];
        assign out_if.ready = out_ready[g];
        assign in_ready[g]  = in_if.ready;
        assign out_valid[g] = out_if.valid;
        assign out_b[g] = {out_if.waddr, out_if.wdata, out_if.we, out_if.csr_we,
                           out_if.csr_waddr, out_if.csr_wdata};
    end

    function automatic bundle_t mk(input logic [4:0] a, input logic [31:0] d, input logic we,
                                   input logic cwe, input logic [11:0] ca, input logic [31:0] cd);
        bundle_t b;
        b.waddr = a; b.wdata = d; b.we = we;
        b.csr_we = cwe; b.csr_waddr = ca; b.csr_wdata = cd;
        return b;
    endfunction

    // Stage can take a bundle: skid instances while fewer than two are held,
    // the plain register when empty or when MEM is draining it this cycle
    function automatic bit mready(input int g);
        if (g != 1) return q[g].size() < 2;
        return (q[g].size() == 0) || out_ready[g];
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input int g, input bundle_t b);
        bit ok;
        ok = 1'b0;
        in_b[g]     = b;
        in_valid[g] = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = mready(g);
            @(posedge clk);
            #1;
        end
        if (!ok) checkOutput("accept_timeout", 128'd0, 128'd1);
        in_valid[g] = 1'b0;
    endtask

    // Model: FIFO of at most two bundles, flush empties it, x0 squash on entry
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int g = 0; g < 3; g++) q[g].delete();
        end else begin
            for (int g = 0; g < 3; g++) begin
                bit      acc;
                bit      rel;
                bundle_t nb;
                acc = in_valid[g] && mready(g);
                rel = (q[g].size() != 0) && out_ready[g];
                if (flush[g]) begin
                    q[g].delete();
                end else begin
                    if (rel) void'(q[g].pop_front());
                    if (acc) begin
                        nb = in_b[g];
                        if (g != 2 && nb.waddr == 5'd0) nb.we = 1'b0;
                        q[g].push_back(nb);
                    end
                end
            end
        end
    end

    // Compare every instance against the model each cycle
    always @(negedge clk) begin
        if (rst) begin
            for (int g = 0; g < 3; g++) begin
                logic [5:0] ectl;
                logic [5:0] actl;
                bit         ev;
                bundle_t    h;
                ev   = q[g].size() != 0;
                h    = ev ? q[g][0] : '0;
                ectl = {ev, mready(g), 2'(q[g].size()), ev & h.we, ev & h.csr_we};
                actl = {out_valid[g], in_ready[g], occ_s[g], out_b[g].we, out_b[g].csr_we};
                checkOutput($sformatf("ctl%0d", g), 128'(actl), 128'(ectl));
                if (ev)
                    checkOutput($sformatf("data%0d", g),
                                128'({out_b[g].waddr, out_b[g].wdata, out_b[g].csr_waddr, out_b[g].csr_wdata}),
                                128'({h.waddr, h.wdata, h.csr_waddr, h.csr_wdata}));
                if (out_valid[g] && out_ready[g] && out_b[g].csr_we && out_b[g].csr_waddr == 12'h305
                    && out_b[g].csr_wdata == 32'h8000_0000)
                    csr_cnt[g]++;
            end
        end
    end

    // Randomise MEM ready for instances in random mode
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int g = 0; g < 3; g++)
                if (rnd_mode[g]) out_ready[g] = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b0;
        flush     = '0;
        in_valid  = '0;
        out_ready = '0;
        rnd_mode  = '0;
        for (int g = 0; g < 3; g++) begin
            in_b[g]    = '0;
            csr_cnt[g] = 0;
        end

        // Reset with a bundle offered
        in_b[0]     = mk(5'd3, 32'h33, 1'b1, 1'b0, 12'h0, 32'h0);
        in_valid[0] = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rst_out_valid", 128'(out_valid[0]), 128'd0);
        checkOutput("rst_out_we", 128'(out_b[0].we), 128'd0);
        checkOutput("rst_occ", 128'(occ_s[0]), 128'd0);
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("first_accept_valid", 128'(out_valid[0]), 128'd1);
        checkOutput("first_accept_waddr", 128'(out_b[0].waddr), 128'd3);
        in_valid[0] = 1'b0;
        out_ready   = 3'b111;
        repeat (2) @(posedge clk);
        #1;

        // Streaming on skid and plain instances
        for (int g = 0; g < 2; g++) begin
            for (int i = 1; i <= 8; i++)
                applyStimulus(g, mk(5'(i), 32'h100 + 32'(i), 1'b1, 1'b0, 12'h0, 32'h0));
            checkOutput($sformatf("stream_waddr%0d", g), 128'(out_b[g].waddr), 128'd8);
            checkOutput($sformatf("stream_wdata%0d", g), 128'(out_b[g].wdata), 128'h108);
            checkOutput($sformatf("stream_occ%0d", g), 128'(occ_s[g]), 128'd1);
            repeat (2) @(posedge clk);
            #1;
        end

        // Skid fill: A, B held, C waits upstream, then drains in order
        out_ready[0] = 1'b0;
        applyStimulus(0, mk(5'd10, 32'hA, 1'b1, 1'b0, 12'h0, 32'h0));
        applyStimulus(0, mk(5'd11, 32'hB, 1'b1, 1'b0, 12'h0, 32'h0));
        in_b[0]     = mk(5'd12, 32'hC, 1'b1, 1'b0, 12'h0, 32'h0);
        in_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("skid_occ", 128'(occ_s[0]), 128'd2);
        checkOutput("skid_in_ready", 128'(in_ready[0]), 128'd0);
        checkOutput("skid_head_A", 128'(out_b[0].waddr), 128'd10);
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("skid_head_B", 128'(out_b[0].waddr), 128'd11);
        checkOutput("skid_ready_back", 128'(in_ready[0]), 128'd1);
        @(posedge clk);
        #1;
        checkOutput("skid_head_C", 128'(out_b[0].waddr), 128'd12);
        in_valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Flush while full with a bundle offered
        out_ready[0] = 1'b0;
        applyStimulus(0, mk(5'd13, 32'hD, 1'b1, 1'b1, 12'h300, 32'h1));
        applyStimulus(0, mk(5'd14, 32'hE, 1'b1, 1'b0, 12'h0, 32'h0));
        in_b[0]     = mk(5'd15, 32'hF, 1'b1, 1'b0, 12'h0, 32'h0);
        in_valid[0] = 1'b1;
        flush[0]    = 1'b1;
        @(posedge clk);
        #1;
        flush[0]    = 1'b0;
        in_valid[0] = 1'b0;
        checkOutput("flush_occ", 128'(occ_s[0]), 128'd0);
        checkOutput("flush_valid", 128'(out_valid[0]), 128'd0);
        checkOutput("flush_we", 128'(out_b[0].we), 128'd0);
        checkOutput("flush_csr_we", 128'(out_b[0].csr_we), 128'd0);
        out_ready[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("flush_no_ghost", 128'(out_valid[0]), 128'd0);

        // x0 squash on, then off
        out_ready[0] = 1'b0;
        out_ready[2] = 1'b0;
        applyStimulus(0, mk(5'd0, 32'hDEADBEEF, 1'b1, 1'b0, 12'h0, 32'h0));
        checkOutput("squash_we", 128'(out_b[0].we), 128'd0);
        checkOutput("squash_wdata", 128'(out_b[0].wdata), 128'hDEADBEEF);
        applyStimulus(2, mk(5'd0, 32'hDEADBEEF, 1'b1, 1'b0, 12'h0, 32'h0));
        checkOutput("nosquash_we", 128'(out_b[2].we), 128'd1);
        checkOutput("nosquash_wdata", 128'(out_b[2].wdata), 128'hDEADBEEF);
        out_ready = 3'b111;
        repeat (2) @(posedge clk);
        #1;

        // CSR bundle under random MEM ready, skid and plain
        for (int g = 0; g < 2; g++) begin
            rnd_mode[g] = 1'b1;
            applyStimulus(g, mk(5'd5, 32'h55, 1'b1, 1'b0, 12'h0, 32'h0));
            applyStimulus(g, mk(5'd6, 32'h66, 1'b0, 1'b1, 12'h305, 32'h8000_0000));
            applyStimulus(g, mk(5'd7, 32'h77, 1'b1, 1'b0, 12'h0, 32'h0));
            applyStimulus(g, mk(5'd8, 32'h88, 1'b1, 1'b1, 12'h341, 32'h4));
            rnd_mode[g] = 1'b0;
            @(posedge clk);
            #2;
            out_ready[g] = 1'b1;
            repeat (4) @(posedge clk);
            #1;
            checkOutput($sformatf("csr_once%0d", g), 128'(csr_cnt[g]), 128'd1);
            checkOutput($sformatf("csr_drained%0d", g), 128'(out_valid[g]), 128'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_mem_pipe.md
Name: ex_mem_pipe

Overview:
- Parametrised EX→MEM pipeline register for the GPR and CSR write-back bundle.
- Replaces the plain always-load stage register with a valid/ready handshake, a synchronous flush and an optional 2-entry skid buffer.
- With the skid buffer, in_ready is a registered output, so no combinational ready path runs back from MEM into EX.
- Sits between ex and mem; the payload passes through unmodified except for the x0 write squash.

Parameters:
- REG_ADDR_W, 5, GPR address width.
- REG_DATA_W, 32, GPR write-data width.
- CSR_ADDR_W, 12, CSR address width.
- CSR_DATA_W, 32, CSR write-data width.
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- ZERO_SQUASH, 1, 1 = a write to GPR address 0 is stored with we=0.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  EX presents a bundle.
- in_ready  out  1  stage can accept a bundle.
- in_waddr  in  REG_ADDR_W  GPR destination.
- in_wdata  in  REG_DATA_W  GPR data.
- in_we  in  1  GPR write enable.
- in_csr_we  in  1  CSR write enable.
- in_csr_waddr  in  CSR_ADDR_W  CSR address.
- in_csr_wdata  in  CSR_DATA_W  CSR data.
- out_valid  out  1  bundle presented to MEM.
- out_ready  in  1  MEM accepts.
- out_waddr, out_wdata, out_we, out_csr_we, out_csr_waddr, out_csr_wdata  out  as inputs  held bundle.
- occ  out  2  number of held entries (0..2; never exceeds 1 when SKID=0).

Behaviour:
- Reset (rst=0, asynchronous):
  - all valid bits, all stored fields and occ clear to 0; out_valid=0.
  - in_ready=1 from deassertion onward.
- Handshakes:
  - Accept when in_valid&in_ready; release when out_valid&out_ready.
  - Latency is 1 cycle: a bundle accepted at edge N is visible on the out_* ports after edge N.
- Output gating:
  - out_we = stored_we & out_valid.
  - out_csr_we = stored_csr_we & out_valid.
  - Data and address fields hold their last value when invalid. Downstream stages without a handshake therefore never see a stale write.
- x0 squash (ZERO_SQUASH=1): in_we=1 with in_waddr=0 is stored with we=0; the address and data are stored unchanged.
- SKID=0:
  - in_ready = ~out_valid | out_ready (combinational).
  - Simultaneous accept and release loads the new bundle: out_valid stays 1.
- SKID=1, states EMPTY (occ=0), ONE (occ=1, main entry valid), TWO (occ=2, main and skid entries valid):
  - in_ready is registered; it is 1 in EMPTY and ONE, and 0 in TWO.
  - EMPTY + accept → ONE.
  - ONE + accept, no release → TWO; the bundle goes to the skid entry.
  - ONE + accept + release → ONE; the new bundle goes to the main entry.
  - ONE + release only → EMPTY.
  - TWO + release → ONE; skid moves to main.
  - In TWO, the cycle after a release raises in_ready.
- Ordering: strictly FIFO; an entry is never dropped or duplicated except by flush.
- flush:
  - Has priority over every handshake.
  - Next state is EMPTY and out_valid=0; a bundle offered in the same cycle is discarded.
  - in_ready=1 the following cycle.
  - A release coinciding with flush still counts as taken by MEM; the block ignores it.
- Reset mid-transfer: contents are lost immediately and outputs go to reset values asynchronously.

Test Plan:
- Reset with in_valid=1 → out_valid=0, out_we=0, occ=0, in_ready=1; first edge after deassertion accepts the bundle.
- Streaming with out_ready=1 and bundles waddr=1..8, wdata=0x100+i → one bundle per cycle out in order, occ stays 1, in_ready stays 1.
- SKID=1, out_ready=0 for 3 cycles with continuous input A,B,C → A,B held, occ=2, in_ready=0, C held upstream. Raising out_ready outputs A, B, C on consecutive cycles.
- Flush while occ=2 with in_valid=1 → next cycle occ=0, out_valid=0, out_we=0, out_csr_we=0; the offered bundle never appears.
- in_we=1, in_waddr=0, wdata=0xDEADBEEF → out_we=0, out_wdata=0xDEADBEEF. With ZERO_SQUASH=0 → out_we=1.
- CSR bundle csr_we=1, csr_waddr=0x305, csr_wdata=0x80000000 under random out_ready (SKID=0 and SKID=1) → arrives intact, exactly once.
